// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the LEGv8 pipeline.
// Holds the PC, drives imem, and loads the IF/ID register.
module fetch_stage #(
    parameter int unsigned      N         = 64,
    parameter logic [N-1:0]     RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'hD503201F
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  IM_readData,
    output logic [N-1:0] IM_addr,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    input  logic         stall,
    input  logic         flush,
    output logic [31:0]  IF_ID_instr,
    output logic [N-1:0] IF_ID_pc,
    output logic         IF_ID_valid,
    output logic [31:0]  fetch_count
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0] pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] ifpc_q, ifpc_d;
    logic         valid_q, valid_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [N-1:0] pc_plus4;
    logic [N-1:0] branch_tgt;
    logic         branch_lsb_unused;

    // Target is forced word aligned; the low two bits never reach the PC.
    assign branch_tgt        = {PCBranch[N-1:2], 2'b00};
    assign branch_lsb_unused = ^PCBranch[1:0];
    assign pc_plus4          = pc_q + PC_STEP;

    // Redirect beats flush beats stall; a plain cycle fetches sequentially.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (PCSrc) begin
            pc_d    = branch_tgt;
            instr_d = NOP_INSTR;
            ifpc_d  = pc_q;
            valid_d = 1'b0;
        end else if (flush) begin
            instr_d = NOP_INSTR;
            ifpc_d  = pc_q;
            valid_d = 1'b0;
            if (!stall) begin
                pc_d = pc_plus4;
            end
        end else if (stall) begin
            pc_d    = pc_q;
        end else begin
            pc_d    = pc_plus4;
            instr_d = IM_readData;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IM_addr     = pc_q;
    assign IF_ID_instr = instr_q;
    assign IF_ID_pc    = ifpc_q;
    assign IF_ID_valid = valid_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, hand sequences,
// and randomized traffic against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IM_readData;
    logic [63:0] IM_addr;
    logic        PCSrc;
    logic [63:0] PCBranch;
    logic        stall;
    logic        flush;
    logic [31:0] IF_ID_instr;
    logic [63:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic [31:0] fetch_count;

    logic [31:0] w_rd;
    logic [63:0] w_addr;
    logic [31:0] w_instr;
    logic [63:0] w_pc;
    logic        w_valid;
    logic [31:0] w_cnt;
    logic        zero = 1'b0;
    logic [63:0] zero64 = '0;

    logic [31:0] mem [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign IM_readData = mem[IM_addr[7:2]];
    assign w_rd        = mem[w_addr[7:2]];

    fetch_stage u_dut (
        .clk(clk), .reset(reset), .IM_readData(IM_readData),
        .IM_addr(IM_addr), .PCSrc(PCSrc), .PCBranch(PCBranch),
        .stall(stall), .flush(flush), .IF_ID_instr(IF_ID_instr),
        .IF_ID_pc(IF_ID_pc), .IF_ID_valid(IF_ID_valid),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .IM_readData(w_rd),
        .IM_addr(w_addr), .PCSrc(zero), .PCBranch(zero64),
        .stall(zero), .flush(zero), .IF_ID_instr(w_instr),
        .IF_ID_pc(w_pc), .IF_ID_valid(w_valid),
        .fetch_count(w_cnt)
    );

    typedef struct {
        logic        pcsrc;
        logic [63:0] br;
        logic        st;
        logic        fl;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [31:0] wd(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ea,
                             input logic [63:0] ep, input logic [31:0] ei,
                             input logic ev, input logic [31:0] ec);
        check({tag, " IM_addr"}, IM_addr, ea);
        check({tag, " IF_ID_pc"}, IF_ID_pc, ep);
        check({tag, " IF_ID_instr"}, 64'(IF_ID_instr), 64'(ei));
        check({tag, " IF_ID_valid"}, 64'(IF_ID_valid), 64'(ev));
        check({tag, " fetch_count"}, 64'(fetch_count), 64'(ec));
    endtask

    task automatic step(input logic ps, input logic [63:0] br,
                        input logic st, input logic fl);
        PCSrc    = ps;
        PCBranch = br;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = wd(i);

        tbl[0]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h4,   64'h0,   wd(0), 1'b1, 32'd1};
        tbl[1]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h8,   64'h4,   wd(1), 1'b1, 32'd2};
        tbl[2]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'hC,   64'h8,   wd(2), 1'b1, 32'd3};
        tbl[3]  = '{1'b0, 64'h0,   1'b1, 1'b0, 64'hC,   64'h8,   wd(2), 1'b1, 32'd3};
        tbl[4]  = '{1'b0, 64'h0,   1'b1, 1'b0, 64'hC,   64'h8,   wd(2), 1'b1, 32'd3};
        tbl[5]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h10,  64'hC,   wd(3), 1'b1, 32'd4};
        tbl[6]  = '{1'b1, 64'h107, 1'b0, 1'b0, 64'h104, 64'h10,  NOP,   1'b0, 32'd4};
        tbl[7]  = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h108, 64'h104, wd(1), 1'b1, 32'd5};
        tbl[8]  = '{1'b1, 64'h20,  1'b1, 1'b1, 64'h20,  64'h108, NOP,   1'b0, 32'd5};
        tbl[9]  = '{1'b0, 64'h0,   1'b0, 1'b1, 64'h24,  64'h20,  NOP,   1'b0, 32'd5};
        tbl[10] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h24,  64'h24,  NOP,   1'b0, 32'd5};
        tbl[11] = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h28,  64'h24,  wd(9), 1'b1, 32'd6};
        tbl[12] = '{1'b0, 64'h0,   1'b1, 1'b0, 64'h28,  64'h24,  wd(9), 1'b1, 32'd6};

        PCSrc = 0; PCBranch = '0; stall = 0; flush = 0;
        reset = 1'b1;
        #1;
        check_all("reset", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
        check("wrap reset IM_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].pcsrc, tbl[i].br, tbl[i].st, tbl[i].fl);
            check_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_pc,
                      tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_cnt);
            if (i == 0) begin
                check("wrap IM_addr", w_addr, 64'h0);
                check("wrap IF_ID_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
                check("wrap IF_ID_instr", 64'(w_instr), 64'(wd(63)));
                check("wrap IF_ID_valid", 64'(w_valid), 64'h1);
            end
        end

        for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
        check("pre-reset IM_addr", IM_addr, 64'h40);
        #2;
        reset = 1'b1;
        #1;
        check_all("async reset", 64'h0, 64'h0, NOP, 1'b0, 32'd0);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            logic        ps, st, fl;
            logic [63:0] br;
            ps = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            br = {$urandom, $urandom};
            if (ps) begin
                m_ifpc = m_pc; m_instr = NOP; m_valid = 0;
                m_pc = br & ~64'h3;
            end else if (fl) begin
                m_ifpc = m_pc; m_instr = NOP; m_valid = 0;
                if (!st) m_pc = m_pc + 64'd4;
            end else if (!st) begin
                m_instr = mem[(m_pc / 4) % 64];
                m_ifpc = m_pc; m_valid = 1;
                m_cnt = m_cnt + 1;
                m_pc = m_pc + 64'd4;
            end
            step(ps, br, st, fl);
            check_all($sformatf("rand%0d", c), m_pc, m_ifpc, m_instr,
                      m_valid, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
